multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencer between the execute stage and the shared multi-cycle multiply/divide unit.
- Accepts one mult or div issue and latches its operands and destination register.
- Issues exactly one single-cycle start pulse to the unit, holds the pipeline stalled while the unit works, and returns one writeback beat.
- Converts unit exceptions and timeouts into the ISA status-register write.

Parameters:
- WIDTH, 32, operand/result width.
- REG_BITS, 5, destination register index width.
- TIMEOUT, 40, max cycles in BUSY before forced abort (must be >= unit worst-case latency + 1).
- EXC_REG, 30, status register index written on exception.
- EXC_MULT, 4, status code for mult overflow/timeout.
- EXC_DIV, 5, status code for divide-by-zero/timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- issue_mult  in  1  execute stage holds a mult this cycle.
- issue_div  in  1  execute stage holds a div this cycle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_rd  in  REG_BITS  destination register.
- flush  in  1  synchronous pipeline flush; abort current op.
- start_mult  out  1  one-cycle start pulse to the unit.
- start_div  out  1  one-cycle start pulse to the unit.
- unit_a  out  WIDTH  latched operand A to the unit.
- unit_b  out  WIDTH  latched operand B to the unit.
- unit_result  in  WIDTH  unit result.
- unit_exc  in  1  unit exception, qualified by unit_rdy.
- unit_rdy  in  1  unit result valid.
- stall  out  1  freeze fetch/decode/execute.
- busy  out  1  state != IDLE.
- wb_valid  out  1  writeback beat.
- wb_rd  out  REG_BITS  writeback register.
- wb_data  out  WIDTH  writeback data.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; all latched registers clear to 0.
  - All outputs are 0.
  - Reset mid-operation discards the op; no wb_valid follows.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - stall = issue_mult | issue_div (combinational, same cycle).
  - On issue: latch op_a, op_b, op_rd and op type; go to START.
  - If both issue inputs are high, mult wins.
- START:
  - Exactly one of start_mult or start_div is 1 for this single cycle.
  - Clear the timeout counter; go to BUSY.
  - stall = 1.
- BUSY:
  - start_* = 0; stall = 1; the counter increments each cycle.
  - unit_rdy=1: register the result, or EXC_REG plus the code if unit_exc=1; go to DONE.
  - No rdy and counter == TIMEOUT-1: take the exception path; go to DONE.
  - unit_rdy takes priority over timeout in the same cycle.
- DONE:
  - wb_valid = 1 for exactly one cycle; stall = 0 so the held instruction retires.
  - Go to IDLE.
  - A new issue sampled in DONE is ignored; it re-presents in the next cycle because the pipeline advances.
- Writeback values:
  - Normal: wb_rd = latched rd, wb_data = unit_result.
  - Exception or timeout: wb_rd = EXC_REG, wb_data = EXC_MULT or EXC_DIV per op type, zero-extended to WIDTH.
- Register writes: wb_rd = 0 with a normal result still produces wb_valid=1; the regfile drops the write.
- unit_a / unit_b: latched values held stable from START until the next issue is accepted.
- Start pulses:
  - Registered from the state, so they are never asserted in two consecutive cycles.
  - A steady issue level produces one pulse per operation (replaces the edge-detect scheme).
- flush=1:
  - In START or BUSY: go to IDLE next cycle with no wb_valid.
  - The unit is not signalled; a late unit_rdy in IDLE is ignored.
  - flush in DONE suppresses wb_valid.
  - flush in IDLE blocks acceptance of an issue.
- Spurious unit_rdy outside BUSY is ignored.

Decomposition:
- Package multdiv_pkg:
  - State enum and op-type enum.
  - EXC_* codes and the EXC_REG default.
  - A function returning the exception code for an op type.
- Sub-module multdiv_timeout_ctr: clog2(TIMEOUT)-bit counter with clear, enable and terminal-count output.
- The FSM and latches stay in the top module.

Test Plan:
- mult 7*6, unit_rdy 16 cycles after start:
  - one start_mult pulse, the cycle after issue;
  - stall high 18 cycles;
  - wb_valid once with wb_rd=op_rd, wb_data=42.
- div 100/0, unit_exc=1 with rdy:
  - wb_rd=30, wb_data=5;
  - start_div pulsed once, start_mult never.
- issue_mult and issue_div both high with 3,4:
  - start_mult only;
  - result written to op_rd.
- unit never asserts rdy, TIMEOUT=40:
  - exactly 40 BUSY cycles, then wb_rd=30, wb_data=4;
  - stall drops in DONE.
- flush asserted on the 5th BUSY cycle, then unit_rdy 3 cycles later:
  - state returns to IDLE;
  - no wb_valid;
  - late rdy ignored.
- reset pulled low mid-BUSY:
  - all outputs 0 immediately (async);
  - after release, a fresh mult 2*3 writes back 6.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and status codes for the multiply/divide sequencer.
package multdiv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   localparam int unsigned EXC_REG_DEF  = 30;
   localparam int unsigned EXC_MULT_DEF = 4;
   localparam int unsigned EXC_DIV_DEF  = 5;

   function automatic int unsigned exc_code(op_e op, int unsigned mult_code, int unsigned div_code);
      return (op == OP_MULT) ? mult_code : div_code;
   endfunction

endpackage

// File: rtl/multdiv_timeout_ctr.sv
// BUSY watchdog: loaded on clear, counts down while enabled, tc at zero.
module multdiv_timeout_ctr #(
   parameter int TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = CW'(TIMEOUT - 1);
      else if (en && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // The load value makes tc fire on the TIMEOUT-th enabled cycle after clear.
   assign tc = (cnt_q == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the shared multi-cycle multiply/divide unit.
//
// state | meaning
// IDLE  | waiting for an issue; stall follows the issue inputs
// START | one-cycle start pulse to the unit, watchdog loaded
// BUSY  | waiting on unit_rdy or watchdog expiry
// DONE  | single writeback beat, pipeline released
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int          WIDTH    = 32,
   parameter int          REG_BITS = 5,
   parameter int          TIMEOUT  = 40,
   parameter int unsigned EXC_REG  = EXC_REG_DEF,
   parameter int unsigned EXC_MULT = EXC_MULT_DEF,
   parameter int unsigned EXC_DIV  = EXC_DIV_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                issue_mult,
   input  logic                issue_div,
   input  logic [WIDTH-1:0]    op_a,
   input  logic [WIDTH-1:0]    op_b,
   input  logic [REG_BITS-1:0] op_rd,
   input  logic                flush,
   output logic                start_mult,
   output logic                start_div,
   output logic [WIDTH-1:0]    unit_a,
   output logic [WIDTH-1:0]    unit_b,
   input  logic [WIDTH-1:0]    unit_result,
   input  logic                unit_exc,
   input  logic                unit_rdy,
   output logic                stall,
   output logic                busy,
   output logic                wb_valid,
   output logic [REG_BITS-1:0] wb_rd,
   output logic [WIDTH-1:0]    wb_data
);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
   logic [REG_BITS-1:0] rd_q, rd_d;
   logic [REG_BITS-1:0] res_rd_q, res_rd_d;
   logic [WIDTH-1:0]    res_data_q, res_data_d;
   logic                ctr_clr, ctr_en, ctr_tc;

   multdiv_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clock (clock),
      .reset (reset),
      .clr   (ctr_clr),
      .en    (ctr_en),
      .tc    (ctr_tc)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      rd_d       = rd_q;
      res_rd_d   = res_rd_q;
      res_data_d = res_data_q;
      ctr_clr    = 1'b0;
      ctr_en     = 1'b0;
      stall      = 1'b0;
      start_mult = 1'b0;
      start_div  = 1'b0;
      wb_valid   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            stall = issue_mult | issue_div;
            if (!flush && (issue_mult || issue_div)) begin
               op_d    = issue_mult ? OP_MULT : OP_DIV;
               a_d     = op_a;
               b_d     = op_b;
               rd_d    = op_rd;
               state_d = ST_START;
            end
         end
         ST_START: begin
            stall      = 1'b1;
            start_mult = (op_q == OP_MULT);
            start_div  = (op_q == OP_DIV);
            ctr_clr    = 1'b1;
            state_d    = flush ? ST_IDLE : ST_BUSY;
         end
         ST_BUSY: begin
            stall  = 1'b1;
            ctr_en = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else if (unit_rdy && !unit_exc) begin
               res_rd_d   = rd_q;
               res_data_d = unit_result;
               state_d    = ST_DONE;
            end else if (unit_rdy || ctr_tc) begin
               res_rd_d   = REG_BITS'(EXC_REG);
               res_data_d = WIDTH'(exc_code(op_q, EXC_MULT, EXC_DIV));
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            wb_valid = !flush;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_MULT;
         a_q        <= '0;
         b_q        <= '0;
         rd_q       <= '0;
         res_rd_q   <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rd_q       <= rd_d;
         res_rd_q   <= res_rd_d;
         res_data_q <= res_data_d;
      end
   end

   assign busy    = (state_q != ST_IDLE);
   assign unit_a  = a_q;
   assign unit_b  = b_q;
   assign wb_rd   = wb_valid ? res_rd_q : '0;
   assign wb_data = wb_valid ? res_data_q : '0;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl; the bench plays the mult/div unit.
module tb_multdiv_ctrl;

   localparam int T    = 40;
   localparam int NCYC = 50;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        issue_mult = 1'b0, issue_div = 1'b0, flush = 1'b0;
   logic [31:0] op_a = '0, op_b = '0, unit_result = '0;
   logic [4:0]  op_rd = '0;
   logic        unit_exc = 1'b0, unit_rdy = 1'b0;
   logic        start_mult, start_div, stall, busy, wb_valid;
   logic [31:0] unit_a, unit_b, wb_data;
   logic [4:0]  wb_rd;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   multdiv_ctrl dut (
      .clock(clock), .reset(reset), .issue_mult(issue_mult), .issue_div(issue_div),
      .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .flush(flush),
      .start_mult(start_mult), .start_div(start_div), .unit_a(unit_a), .unit_b(unit_b),
      .unit_result(unit_result), .unit_exc(unit_exc), .unit_rdy(unit_rdy),
      .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   // Runs one operation over NCYC cycles. Cycle 0 presents the issue; the unit
   // raises rdy on BUSY cycle rdy_at (0 = never); flush is raised on cycle 1+flush_at.
   task automatic do_op(input bit im, input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [4:0] rd, input int rdy_at,
                        input int flush_at, input bit exc,
                        output int n_sm, output int n_sd, output int start_c, output int n_stall,
                        output int n_busy, output int n_wb, output int wb_c,
                        output logic [4:0] o_rd, output logic [31:0] o_data,
                        output logic [31:0] o_ua, output logic [31:0] o_ub,
                        output bit stall_at_wb, output bit ua_held);
      n_sm = 0; n_sd = 0; start_c = -1; n_stall = 0; n_busy = 0; n_wb = 0; wb_c = -1;
      o_rd = '0; o_data = '0; o_ua = '0; o_ub = '0; stall_at_wb = 1'b1;
      for (int c = 0; c < NCYC; c++) begin
         @(negedge clock);
         issue_mult  = (c == 0) && im;
         issue_div   = (c == 0) && id;
         op_a        = (c == 0) ? a : $urandom;
         op_b        = (c == 0) ? b : $urandom;
         op_rd       = (c == 0) ? rd : 5'($urandom);
         unit_rdy    = (rdy_at > 0) && (c == 1 + rdy_at);
         unit_exc    = unit_rdy && exc;
         unit_result = unit_rdy ? res : $urandom;
         flush       = (flush_at > 0) && (c == 1 + flush_at);
         #1;
         if (start_mult || start_div) begin
            if (start_c < 0) start_c = c;
            o_ua = unit_a; o_ub = unit_b;
         end
         if (start_mult) n_sm++;
         if (start_div) n_sd++;
         if (stall) n_stall++;
         if (busy && stall && !start_mult && !start_div) n_busy++;
         if (wb_valid) begin
            n_wb++; wb_c = c; o_rd = wb_rd; o_data = wb_data; stall_at_wb = stall;
         end
      end
      ua_held = (unit_a === a) && (unit_b === b);
      @(negedge clock);
      issue_mult = 0; issue_div = 0; unit_rdy = 0; unit_exc = 0; flush = 0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if ({start_mult, start_div, stall, busy, wb_valid, wb_rd, wb_data, unit_a, unit_b} !== '0) begin
         errors++; $display("FAIL reset_outputs got busy=%0b stall=%0b wb=%0b exp all 0", busy, stall, wb_valid); end
      @(negedge clock); reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %0b exp 0", busy); end
   endtask

   task automatic test_mult_basic();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      do_op(1, 0, 32'd7, 32'd6, 32'd42, 5'd9, 16, 0, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (n_sm !== 1 || n_sd !== 0) begin errors++; $display("FAIL mult_starts got %0d/%0d exp 1/0", n_sm, n_sd); end
      checks++; if (sc !== 1) begin errors++; $display("FAIL mult_start_cycle got %0d exp 1", sc); end
      checks++; if (ns !== 18) begin errors++; $display("FAIL mult_stall_cycles got %0d exp 18", ns); end
      checks++; if (nw !== 1 || r !== 5'd9 || d !== 32'd42) begin
         errors++; $display("FAIL mult_wb got n=%0d rd=%0d data=%0d exp 1/9/42", nw, r, d); end
      checks++; if (ua !== 32'd7 || ub !== 32'd6) begin errors++; $display("FAIL mult_unit_ops got %0d,%0d exp 7,6", ua, ub); end
   endtask

   task automatic test_div_exc();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      do_op(0, 1, 32'd100, 32'd0, 32'hdead, 5'd4, 7, 0, 1, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (n_sm !== 0 || n_sd !== 1) begin errors++; $display("FAIL div_starts got %0d/%0d exp 0/1", n_sm, n_sd); end
      checks++; if (nw !== 1 || r !== 5'd30 || d !== 32'd5) begin
         errors++; $display("FAIL div_exc_wb got n=%0d rd=%0d data=%0d exp 1/30/5", nw, r, d); end
   endtask

   task automatic test_both_issue();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      do_op(1, 1, 32'd3, 32'd4, 32'd12, 5'd17, 5, 0, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (n_sm !== 1 || n_sd !== 0) begin errors++; $display("FAIL both_starts got %0d/%0d exp 1/0", n_sm, n_sd); end
      checks++; if (r !== 5'd17 || d !== 32'd12) begin errors++; $display("FAIL both_wb got rd=%0d data=%0d exp 17/12", r, d); end
   endtask

   task automatic test_timeout();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      do_op(1, 0, 32'd5, 32'd5, 32'd25, 5'd2, 0, 0, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (nb !== T) begin errors++; $display("FAIL timeout_busy_cycles got %0d exp %0d", nb, T); end
      checks++; if (nw !== 1 || r !== 5'd30 || d !== 32'd4) begin
         errors++; $display("FAIL timeout_wb got n=%0d rd=%0d data=%0d exp 1/30/4", nw, r, d); end
      checks++; if (sw !== 1'b0) begin errors++; $display("FAIL timeout_stall_in_done got %0b exp 0", sw); end
      // rdy arriving on the last BUSY cycle still wins over the watchdog
      do_op(0, 1, 32'd8, 32'd2, 32'd4, 5'd11, T, 0, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (r !== 5'd11 || d !== 32'd4) begin errors++; $display("FAIL rdy_at_limit got rd=%0d data=%0d exp 11/4", r, d); end
   endtask

   task automatic test_flush();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      do_op(1, 0, 32'd9, 32'd9, 32'd81, 5'd3, 8, 5, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (nw !== 0) begin errors++; $display("FAIL flush_busy_wb got %0d beats exp 0", nw); end
      checks++; if (ns !== 7) begin errors++; $display("FAIL flush_stall_cycles got %0d exp 7", ns); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle busy got %0b exp 0", busy); end
      // flush coinciding with DONE (op finishing on BUSY cycle 3)
      do_op(0, 1, 32'd6, 32'd3, 32'd2, 5'd8, 3, 4, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (nw !== 0) begin errors++; $display("FAIL flush_done_wb got %0d beats exp 0", nw); end
      @(negedge clock); issue_mult = 1; flush = 1;
      @(negedge clock); issue_mult = 0; flush = 0;
      repeat (3) begin
         #1; checks++; if (start_mult !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_block got start=%0b busy=%0b exp 0/0", start_mult, busy); end
         @(negedge clock);
      end
   endtask

   task automatic test_reset_mid();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      int late_wb = 0;
      @(negedge clock); issue_mult = 1; op_a = 32'd11; op_b = 32'd13; op_rd = 5'd6;
      @(negedge clock); issue_mult = 0;
      repeat (4) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++; if ({start_mult, start_div, stall, busy, wb_valid, wb_rd, wb_data, unit_a, unit_b} !== '0) begin
         errors++; $display("FAIL reset_mid_outputs got busy=%0b stall=%0b ua=%0d exp all 0", busy, stall, unit_a); end
      @(negedge clock); reset = 1'b1; unit_rdy = 1; unit_result = 32'd143;
      repeat (4) begin #1; if (wb_valid) late_wb++; @(negedge clock); unit_rdy = 0; end
      checks++; if (late_wb !== 0) begin errors++; $display("FAIL reset_mid_no_wb got %0d beats exp 0", late_wb); end
      do_op(1, 0, 32'd2, 32'd3, 32'd6, 5'd21, 4, 0, 0, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
      checks++; if (nw !== 1 || r !== 5'd21 || d !== 32'd6) begin
         errors++; $display("FAIL reset_mid_fresh got n=%0d rd=%0d data=%0d exp 1/21/6", nw, r, d); end
   endtask

   task automatic test_back_to_back();
      int last_s = -100, prev_start = -100, n_s = 0, n_w = 0, exp_s = 0;
      // steady issue: each op takes accept + START + 2 BUSY + DONE = 5 cycles
      for (int k = 0; 1 + 5 * k < 25; k++) exp_s++;
      for (int c = 0; c < 25; c++) begin
         @(negedge clock);
         issue_mult  = 1; op_a = $urandom; op_b = $urandom; op_rd = 5'd7;
         unit_rdy    = (c == last_s + 2);
         unit_result = 32'd100 + 32'(c);
         #1;
         if (start_mult) begin
            checks++; if (prev_start == c - 1) begin errors++; $display("FAIL b2b_consecutive_start at cycle %0d", c); end
            n_s++; last_s = c; prev_start = c;
         end
         if (wb_valid) begin
            n_w++;
            checks++; if (wb_data !== 32'd100 + 32'(c - 1)) begin
               errors++; $display("FAIL b2b_wb_data got %0d exp %0d", wb_data, 100 + c - 1); end
         end
      end
      @(negedge clock); issue_mult = 0; unit_rdy = 0;
      repeat (6) @(negedge clock);
      checks++; if (n_s !== exp_s || n_w !== exp_s) begin
         errors++; $display("FAIL b2b_counts got starts=%0d wbs=%0d exp %0d", n_s, n_w, exp_s); end
   endtask

   task automatic test_random();
      int n_sm, n_sd, sc, ns, nb, nw, wc; logic [4:0] r; logic [31:0] d, ua, ub; bit sw, h;
      for (int i = 0; i < 20; i++) begin
         int sel = $urandom_range(0, 2);
         bit im = (sel != 1), id = (sel != 0), is_m = im;
         logic [31:0] a = $urandom, b = $urandom, res = $urandom;
         logic [4:0] rd = 5'($urandom);
         int rdy_at = $urandom_range(1, 45);
         bit exc = ($urandom_range(0, 3) == 0);
         bit to = (rdy_at > T);
         int eff = to ? T : rdy_at;
         logic [4:0] e_rd = (to || exc) ? 5'd30 : rd;
         logic [31:0] e_data = (to || exc) ? (is_m ? 32'd4 : 32'd5) : res;
         do_op(im, id, a, b, res, rd, rdy_at, 0, exc, n_sm, n_sd, sc, ns, nb, nw, wc, r, d, ua, ub, sw, h);
         checks++; if (n_sm !== int'(is_m) || n_sd !== int'(!is_m) || sc !== 1) begin
            errors++; $display("FAIL rnd%0d_start got m=%0d d=%0d at %0d exp m=%0d", i, n_sm, n_sd, sc, is_m); end
         checks++; if (nw !== 1 || wc !== 2 + eff || r !== e_rd || d !== e_data) begin
            errors++; $display("FAIL rnd%0d_wb got n=%0d c=%0d rd=%0d data=%h exp 1/%0d/%0d/%h", i, nw, wc, r, d, 2 + eff, e_rd, e_data); end
         checks++; if (ns !== 2 + eff || nb !== eff) begin
            errors++; $display("FAIL rnd%0d_stall got stall=%0d busy=%0d exp %0d/%0d", i, ns, nb, 2 + eff, eff); end
         checks++; if (ua !== a || ub !== b || !h) begin
            errors++; $display("FAIL rnd%0d_operands got %h,%h held=%0b exp %h,%h", i, ua, ub, h, a, b); end
      end
   endtask

   initial begin
      test_reset();
      test_mult_basic();
      test_div_exc();
      test_both_issue();
      test_timeout();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
